pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Elastic pipeline stage carrying a data bus and a control bus between two CPU stages, such as ID->EX.
- Uses a valid/ready handshake on both sides, so downstream back-pressure (multi-cycle EX, memory wait) stalls upstream without dropping or duplicating entries.
- Holds up to two entries: a main slot and a skid slot.
- in_ready is fully registered, which breaks the combinational ready path between stages.
- Supports a synchronous flush for branch/exception squash.

Parameters:
- width_a, 32, width of the data bus (in_data/out_data).
- width_b, 32, width of the control bus (in_ctrl/out_ctrl).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries; active high.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  stage can accept an entry this cycle. Registered.
- in_data  input  width_a  upstream data.
- in_ctrl  input  width_b  upstream control word.
- out_valid  output  1  out_data/out_ctrl hold a valid entry.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_data  output  width_a  data of the oldest held entry.
- out_ctrl  output  width_b  control of the oldest held entry.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Reset (reset==0, asynchronous) clears everything:
  - state=EMPTY; out_valid=0; in_ready=1; occupancy=0.
  - out_data=0; out_ctrl=0; skid slot data/ctrl=0.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - All updates occur on the rising clock edge.
- Upstream rules:
  - in_valid while in_ready=0 is ignored.
  - Upstream must hold in_data/in_ctrl stable until in_fire.
- out_valid is asserted only from state.
- Latency is 1 cycle from in_fire to out_valid. Throughput is 1 entry/cycle while out_ready=1.
- Order is strictly FIFO.
- States (occupancy 0/1/2):
  - EMPTY: in_fire -> FULL, main<=in.
  - FULL:
    - in_fire & out_fire -> FULL, main<=in.
    - in_fire & !out_ready -> SKID, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - SKID: in_ready=0.
    - out_fire -> FULL, main<=skid, skid<=0.
    - Otherwise hold.
- in_ready is registered as next_state != SKID.
- out_valid = (state != EMPTY).
- out_data/out_ctrl:
  - Always reflect the main slot.
  - Not updated while held unfired.
  - Retain their last value when moving to EMPTY; zero after reset or flush.
- Flush:
  - Has priority over every simultaneous event.
  - Next state=EMPTY; main and skid data/ctrl cleared to 0.
  - Any in_fire in the flush cycle is discarded.
  - out_fire in that cycle still counts as consumed downstream.
  - in_ready=1 on the following cycle.
- Flush while EMPTY has no effect beyond zeroing the slots.
- Reset asserted mid-operation drops all entries immediately. After reset deasserts, the first edge behaves as EMPTY.
- No arithmetic. occupancy is state-encoded and never exceeds 2.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
  - occupancy constants.
- One natural sub-module: pipe_slot.
  - Parameterised width_a/width_b data+ctrl register.
  - Has load and clear inputs and async active-low reset to 0.
  - Instantiated twice (main, skid).

Test Plan:
1. Reset and steady streaming:
   - Stimulus: after reset check out_valid=0, in_ready=1, out_data=0. Stream in_data=1..8 with in_valid=1, out_ready=1.
   - Response: out_data 1..8 appear one cycle later, one per cycle; occupancy stays 1.
2. Back-pressure into skid:
   - Stimulus: send A=0x11, then B=0x22 with out_ready=0.
   - Response: occupancy 2, in_ready=0 next cycle, in_valid C=0x33 ignored. Raising out_ready yields A, B, C in order with no loss or duplication.
3. Drain to empty:
   - Stimulus: hold in_valid=0, out_ready=1 from occupancy 2.
   - Response: two fires, then out_valid=0, occupancy 0, out_data retains the last value 0x22.
4. Flush with simultaneous input:
   - Stimulus: assert flush at occupancy 2 while in_valid=1 with 0x44.
   - Response: next cycle out_valid=0, occupancy 0, out_data=0, out_ctrl=0, in_ready=1. 0x44 never appears.
5. Mid-operation reset:
   - Stimulus: assert reset asynchronously between edges at occupancy 1.
   - Response: out_valid and out_data drop to 0 immediately; after release, the first accepted entry emerges normally.
6. Random valid/ready:
   - Stimulus: random toggling for 10k cycles with a scoreboard.
   - Response: output sequence equals input sequence; in_ready never 1 while occupancy=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage.
//   - pipe_state_t : state encoding of the stage controller (EMPTY/FULL/SKID)
//   - OCC_*        : occupancy constants (number of held entries)
//   - state_occupancy() : maps a controller state onto its entry count
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Occupancy is purely state-encoded; the unused encoding reads as empty.
    function automatic logic [1:0] state_occupancy(input pipe_state_t state);
        logic [1:0] occ;
        case (state)
            ST_EMPTY: occ = OCC_EMPTY;
            ST_FULL:  occ = OCC_ONE;
            ST_SKID:  occ = OCC_TWO;
            default:  occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one data+control holding register of the skid stage.
// Ports:
//   clock, reset (async, active-low, clears to 0)
//   load       : capture load_data/load_ctrl on the rising edge
//   clear      : synchronous zeroing, wins over load
//   load_data  : width_a bits to capture
//   load_ctrl  : width_b bits to capture
//   data, ctrl : current slot contents (registered)
module pipe_slot #(
    parameter int width_a = 32,
    parameter int width_b = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [width_a-1:0] load_data,
    input  logic [width_b-1:0] load_ctrl,
    output logic [width_a-1:0] data,
    output logic [width_b-1:0] ctrl
);
    import pipe_pkg::*;

    // Slot register: clear beats load so a squash never leaves stale entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data <= {width_a{1'b0}};
            ctrl <= {width_b{1'b0}};
        end else if (clear) begin
            data <= {width_a{1'b0}};
            ctrl <= {width_b{1'b0}};
        end else if (load) begin
            data <= load_data;
            ctrl <= load_ctrl;
        end else begin
            data <= data;
            ctrl <= ctrl;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry elastic pipeline stage (main + skid slot)
// between two CPU stages with valid/ready handshakes on both sides.
// Ports:
//   clock, reset (async, active-low)
//   flush                 : synchronous squash of every held entry
//   in_valid/in_ready     : upstream handshake; in_ready is registered
//   in_data/in_ctrl       : upstream entry (width_a / width_b)
//   out_valid/out_ready   : downstream handshake
//   out_data/out_ctrl     : oldest held entry (the main slot)
//   occupancy             : number of held entries, 0..2
module pipe_skid_stage #(
    parameter int width_a = 32,
    parameter int width_b = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width_a-1:0] in_data,
    input  logic [width_b-1:0] in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width_a-1:0] out_data,
    output logic [width_b-1:0] out_ctrl,
    output logic [1:0]         occupancy
);
    import pipe_pkg::*;

    pipe_state_t        state_r;
    pipe_state_t        next_state_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [1:0]         occupancy_r;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               main_load_s;
    logic               main_clear_s;
    logic               main_from_skid_s;
    logic               skid_load_s;
    logic               skid_clear_s;
    logic [width_a-1:0] main_in_data_s;
    logic [width_b-1:0] main_in_ctrl_s;
    logic [width_a-1:0] skid_data_s;
    logic [width_b-1:0] skid_ctrl_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Next-state and slot-control decode; flush overrides every other event.
    always_comb begin
        next_state_s     = state_r;
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (flush) begin
            next_state_s = ST_EMPTY;
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        next_state_s = ST_FULL;
                        main_load_s  = 1'b1;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        main_load_s = 1'b1;
                    end else if (in_fire_s) begin
                        // Downstream stalled: park the newcomer behind main.
                        next_state_s = ST_SKID;
                        skid_load_s  = 1'b1;
                    end else if (out_fire_s) begin
                        // Main keeps its value; only out_valid drops.
                        next_state_s = ST_EMPTY;
                    end else begin
                        next_state_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire_s) begin
                        next_state_s     = ST_FULL;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                    end else begin
                        next_state_s = ST_SKID;
                    end
                end
                default: begin
                    next_state_s = ST_EMPTY;
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // Main slot source: the skid entry when draining SKID, else upstream.
    always_comb begin
        if (main_from_skid_s) begin
            main_in_data_s = skid_data_s;
            main_in_ctrl_s = skid_ctrl_s;
        end else begin
            main_in_data_s = in_data;
            main_in_ctrl_s = in_ctrl;
        end
    end

    // Controller state plus registered handshake/occupancy outputs, all
    // derived from the next state so they line up with state_r.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= OCC_EMPTY;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != ST_SKID);
            out_valid_r <= (next_state_s != ST_EMPTY);
            occupancy_r <= state_occupancy(next_state_s);
        end
    end

    pipe_slot #(.width_a(width_a), .width_b(width_b)) u_main_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (main_load_s),
        .clear     (main_clear_s),
        .load_data (main_in_data_s),
        .load_ctrl (main_in_ctrl_s),
        .data      (out_data),
        .ctrl      (out_ctrl)
    );

    pipe_slot #(.width_a(width_a), .width_b(width_b)) u_skid_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load_s),
        .clear     (skid_clear_s),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .data      (skid_data_s),
        .ctrl      (skid_ctrl_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign occupancy = occupancy_r;

endmodule
